// File: rtl/hazard_controller_if.sv
// Pipeline hazard bundle between the RV32I datapath (master) and the
// hazard controller (slave).
interface hazard_controller_if;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        if_id_uses_rs1;
  logic        if_id_uses_rs2;
  logic [4:0]  id_ex_rd;
  logic        id_ex_memread;
  logic        ex_branch_taken;
  logic        ex_mem_memreq;
  logic        dmem_ready;
  logic        perf_clr;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_bubble;
  logic        fault;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
           id_ex_rd, id_ex_memread, ex_branch_taken, ex_mem_memreq,
           dmem_ready, perf_clr,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble, fault,
           stall_cycles, flush_count
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
           id_ex_rd, id_ex_memread, ex_branch_taken, ex_mem_memreq,
           dmem_ready, perf_clr,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble, fault,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Stage enable / flush / bubble sequencing for the 5-stage RV32I pipeline,
// with data-memory wait timeout and saturating stall/flush counters.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int WAIT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [31:0]       stall_cycles_reg;
  logic [15:0]       flush_count_reg;

  logic [4:0] src_reg_num [2];
  logic [1:0] src_used;
  logic [1:0] src_hit;
  logic       freeze;
  logic       loaduse_hit;

  logic dec_freeze;
  logic dec_branch;
  logic dec_loaduse;
  logic pc_write_next;
  logic if_id_write_next;
  logic id_ex_write_next;
  logic ex_mem_write_next;
  logic if_id_flush_next;
  logic id_ex_flush_next;
  logic mem_wb_bubble_next;

  assign src_reg_num[0] = hz.if_id_rs1;
  assign src_reg_num[1] = hz.if_id_rs2;
  assign src_used       = {hz.if_id_uses_rs2, hz.if_id_uses_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_reg_num[gi] == hz.id_ex_rd);
    end
  endgenerate

  assign freeze      = hz.ex_mem_memreq && !hz.dmem_ready;
  assign loaduse_hit = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) && (|src_hit);

  always_comb begin
    dec_freeze         = 1'b0;
    dec_branch         = 1'b0;
    dec_loaduse        = 1'b0;
    pc_write_next      = 1'b1;
    if_id_write_next   = 1'b1;
    id_ex_write_next   = 1'b1;
    ex_mem_write_next  = 1'b1;
    if_id_flush_next   = 1'b0;
    id_ex_flush_next   = 1'b0;
    mem_wb_bubble_next = 1'b0;
    if (rst || state_reg == FAULT) begin
      pc_write_next      = 1'b0;
      if_id_write_next   = 1'b0;
      id_ex_write_next   = 1'b0;
      ex_mem_write_next  = 1'b0;
      if_id_flush_next   = 1'b1;
      id_ex_flush_next   = 1'b1;
      mem_wb_bubble_next = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds; MEM/WB gets a NOP so WB does not repeat the access.
      dec_freeze         = 1'b1;
      pc_write_next      = 1'b0;
      if_id_write_next   = 1'b0;
      id_ex_write_next   = 1'b0;
      ex_mem_write_next  = 1'b0;
      mem_wb_bubble_next = 1'b1;
    end else if (hz.ex_branch_taken) begin
      dec_branch         = 1'b1;
      if_id_flush_next   = 1'b1;
      id_ex_flush_next   = 1'b1;
    end else if (loaduse_hit) begin
      dec_loaduse        = 1'b1;
      pc_write_next      = 1'b0;
      if_id_write_next   = 1'b0;
      id_ex_flush_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      wait_cnt_reg     <= '0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (freeze) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // A dropped memreq releases exactly like dmem_ready does.
          if (!freeze) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg == TIMEOUT_CNT) begin
            state_reg    <= FAULT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        FAULT:   state_reg <= FAULT;
        default: state_reg <= RUN;
      endcase

      if (hz.perf_clr) begin
        stall_cycles_reg <= '0;
        flush_count_reg  <= '0;
      end else begin
        if ((dec_freeze || dec_loaduse) && (stall_cycles_reg != '1))
          stall_cycles_reg <= stall_cycles_reg + 32'd1;
        if (dec_branch && (flush_count_reg != '1))
          flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign hz.pc_write      = pc_write_next;
  assign hz.if_id_write   = if_id_write_next;
  assign hz.id_ex_write   = id_ex_write_next;
  assign hz.ex_mem_write  = ex_mem_write_next;
  assign hz.if_id_flush   = if_id_flush_next;
  assign hz.id_ex_flush   = id_ex_flush_next;
  assign hz.mem_wb_bubble = mem_wb_bubble_next;
  assign hz.fault         = (state_reg == FAULT);
  assign hz.stall_cycles  = stall_cycles_reg;
  assign hz.flush_count   = flush_count_reg;

endmodule
